fb_scaler: RTL and testbench



---
 rtl/video_pkg.sv | 20 ++
 rtl/fb_addr_gen.sv | 78 +++++++
 rtl/fb_scaler.sv | 84 ++++++++
 tb/tb_fb_scaler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video timing constants, colour types and the 3-bit to 24-bit palette.
package video_pkg;

  localparam int unsigned SRC_W    = 160;
  localparam int unsigned SRC_H    = 120;
  localparam int unsigned SCALE_SH = 2;
  localparam int unsigned ACT_W    = 640;
  localparam int unsigned ACT_H    = 480;
  localparam int unsigned FRAME_W  = 800;
  localparam int unsigned FRAME_H  = 525;

  typedef logic [2:0]  rgb3_t;
  typedef logic [23:0] rgb24_t;

  // Each colour bit saturates its 8-bit channel: bit2=R, bit1=G, bit0=B.
  function automatic rgb24_t palette3to24(input rgb3_t p);
    return {{8{p[2]}}, {8{p[1]}}, {8{p[0]}}};
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Raster lookahead (stage 1) and framebuffer address/enable registers (stage 2).
module fb_addr_gen
  import video_pkg::*;
#(
  parameter int unsigned LEAD = 4
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic [9:0]  cx,
  input  logic [9:0]  cy,
  input  logic        mode_next,
  output logic        origin,
  output logic        act,
  output logic [14:0] fb_addr,
  output logic        fb_ce
);

  logic [10:0] ax_sum;
  logic [9:0]  ax_c, ay_c;
  logic        in_range, act_c, origin_c;

  logic [9:0]  ax_q, ay_q;
  logic        act1_q, origin_q, act2_q;
  logic [14:0] addr_q;
  logic        ce_q;
  logic [9:0]  sx, sy;

  always_comb begin
    ax_sum   = {1'b0, cx} + 11'(LEAD);
    in_range = (cx < 10'(FRAME_W)) && (cy < 10'(FRAME_H));
    ax_c     = ax_sum[9:0];
    ay_c     = cy;
    if (ax_sum >= 11'(FRAME_W)) begin
      ax_c = 10'(ax_sum - 11'(FRAME_W));
      ay_c = (cy == 10'(FRAME_H - 1)) ? 10'd0 : cy + 10'd1;
    end
    act_c    = in_range && (ax_c < 10'(ACT_W)) && (ay_c < 10'(ACT_H));
    origin_c = in_range && (ax_c == 10'd0) && (ay_c == 10'd0);
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      ax_q     <= '0;
      ay_q     <= '0;
      act1_q   <= 1'b0;
      origin_q <= 1'b0;
    end else begin
      ax_q     <= ax_c;
      ay_q     <= ay_c;
      act1_q   <= act_c;
      origin_q <= origin_c;
    end
  end

  assign sx = ax_q >> SCALE_SH;
  assign sy = ay_q >> SCALE_SH;

  // sy*160 + sx as shift-add; max 119*160+159 = 19199 fits in 15 bits.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      addr_q <= '0;
      ce_q   <= 1'b0;
      act2_q <= 1'b0;
    end else begin
      if (act1_q) begin
        addr_q <= ({5'd0, sy} << 7) + ({5'd0, sy} << 5) + {5'd0, sx};
      end
      ce_q   <= act1_q && !mode_next;
      act2_q <= act1_q;
    end
  end

  assign origin  = origin_q;
  assign act     = act2_q;
  assign fb_addr = addr_q;
  assign fb_ce   = ce_q;

endmodule

// File: rtl/fb_scaler.sv
// 4x4 framebuffer upscaler with frame-aligned menu/game source select and palette.
module fb_scaler
  import video_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned LEAD   = RD_LAT + 3
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic [9:0]  cx,
  input  logic [9:0]  cy,
  input  logic        game_start,
  input  logic [2:0]  game_rgb,
  output logic [14:0] fb_addr,
  output logic        fb_ce,
  input  logic [2:0]  fb_dout,
  output logic        game_mode,
  output logic [23:0] rgb
);

  logic              gs_q1, gs_q2, mode_q, mode_next;
  logic              origin, act2;
  logic [RD_LAT-1:0] act_dl, tag_dl;
  rgb3_t             pix;
  rgb24_t            rgb_q;

  // Source only changes when the lookahead lands on pixel (0,0).
  assign mode_next = origin ? gs_q2 : mode_q;

  fb_addr_gen #(
    .LEAD (LEAD)
  ) u_addr_gen (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .cx        (cx),
    .cy        (cy),
    .mode_next (mode_next),
    .origin    (origin),
    .act       (act2),
    .fb_addr   (fb_addr),
    .fb_ce     (fb_ce)
  );

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      gs_q1  <= 1'b0;
      gs_q2  <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      gs_q1  <= game_start;
      gs_q2  <= gs_q1;
      mode_q <= mode_next;
    end
  end

  // mode_q is the source tag of the pixel currently in stage 2.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      act_dl <= '0;
      tag_dl <= '0;
    end else begin
      act_dl[0] <= act2;
      tag_dl[0] <= mode_q;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        act_dl[i] <= act_dl[i-1];
        tag_dl[i] <= tag_dl[i-1];
      end
    end
  end

  assign pix = tag_dl[RD_LAT-1] ? game_rgb : fb_dout;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= act_dl[RD_LAT-1] ? palette3to24(pix) : 24'h000000;
    end
  end

  assign game_mode = mode_q;
  assign rgb       = rgb_q;

endmodule

// File: tb/tb_fb_scaler.sv
// Directed bench for fb_scaler with a per-cycle raster/ROM reference model.
module tb_fb_scaler;
  import video_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  cx, cy;
  logic        game_start;
  logic [2:0]  game_rgb;
  logic [14:0] fb_addr;
  logic        fb_ce;
  logic [2:0]  fb_dout = 3'd0;
  logic        game_mode;
  logic [23:0] rgb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fb_scaler dut (
    .clk_pixel  (clk),
    .reset      (reset),
    .cx         (cx),
    .cy         (cy),
    .game_start (game_start),
    .game_rgb   (game_rgb),
    .fb_addr    (fb_addr),
    .fb_ce      (fb_ce),
    .fb_dout    (fb_dout),
    .game_mode  (game_mode),
    .rgb        (rgb)
  );

  // ROM contents: successive source pixels walk through all 8 colours, address 0 is red.
  function automatic logic [2:0] rom_val(input int a);
    return 3'((a + 4) % 8);
  endfunction

  // Framebuffer ROM with one cycle of read latency.
  always @(posedge clk) begin
    if (fb_ce) fb_dout <= rom_val(int'(fb_addr));
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t cx=%0d cy=%0d)", name, got, exp, $time,
               cx, cy);
    end
  endtask

  // Pixel that the raster reaches 4 cycles after (x,y).
  function automatic void lookahead(input int x, input int y, output bit act, output bit origin,
                                    output int addr);
    int ax, ay;
    bit inr;
    inr = (x < 800) && (y < 525);
    ax = x + 4;
    ay = y;
    if (ax >= 800) begin
      ax -= 800;
      ay = (y + 1 == 525) ? 0 : y + 1;
    end
    act = inr && (ax < 640) && (ay < 480);
    origin = inr && (ax == 0) && (ay == 0);
    addr = (ay / 4) * 160 + (ax / 4);
  endfunction

  // Reference model histories, indexed by clock edge modulo 8.
  bit h_rst[8];
  int h_x[8], h_y[8];
  bit h_gs[8];
  bit h_mode[8];
  int k = 0;
  bit m_mode = 1'b0;
  int m_addr = 0;

  function automatic int ix(input int d);
    return (k - d + 8) % 8;
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) begin
      h_rst[i] = 1'b1;
      h_x[i] = 0;
      h_y[i] = 0;
      h_gs[i] = 1'b0;
      h_mode[i] = 1'b0;
    end
  end

  initial begin
    bit a1, o1, a3, o3, ok3;
    int ad1, ad3;
    bit e_ce;
    logic [23:0] e_rgb;
    logic [2:0] cur_grgb;
    forever begin
      @(posedge clk);
      h_rst[ix(0)] = reset;
      h_x[ix(0)] = int'(cx);
      h_y[ix(0)] = int'(cy);
      h_gs[ix(0)] = game_start;
      cur_grgb = game_rgb;
      lookahead(h_x[ix(1)], h_y[ix(1)], a1, o1, ad1);
      if (reset) begin
        m_mode = 1'b0;
        m_addr = 0;
      end else begin
        if (!h_rst[ix(1)] && o1) m_mode = h_rst[ix(2)] ? 1'b0 : h_gs[ix(2)];
        if (!h_rst[ix(1)] && a1) m_addr = ad1;
      end
      e_ce = !reset && !h_rst[ix(1)] && a1 && !m_mode;
      h_mode[ix(0)] = m_mode;
      lookahead(h_x[ix(3)], h_y[ix(3)], a3, o3, ad3);
      ok3 = a3 && !h_rst[ix(0)] && !h_rst[ix(1)] && !h_rst[ix(2)] && !h_rst[ix(3)];
      e_rgb = ok3 ? palette3to24(h_mode[ix(2)] ? cur_grgb : rom_val(ad3)) : 24'h000000;
      k++;
      #1;
      chk("model_rgb", 32'(rgb), 32'(e_rgb));
      chk("model_fb_ce", 32'(fb_ce), 32'(e_ce));
      chk("model_fb_addr", 32'(fb_addr), 32'(m_addr));
      chk("model_game_mode", 32'(game_mode), 32'(m_mode));
    end
  end

  task automatic step(input int x, input int y);
    @(negedge clk);
    cx = 10'(x);
    cy = 10'(y);
  endtask

  // Drive n consecutive raster positions starting at (x0,y0); ends with the last one driven.
  task automatic scan(input int x0, input int y0, input int n);
    int x, y;
    x = x0;
    y = y0;
    for (int i = 0; i < n; i++) begin
      step(x, y);
      x++;
      if (x == 800) begin
        x = 0;
        y = (y + 1) % 525;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    cx = '0;
    cy = '0;
    game_start = 1'b0;
    game_rgb = 3'b000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_rgb", 32'(rgb), 32'h0);
    chk("reset_fb_ce", 32'(fb_ce), 32'h0);

    // Frame-start prefetch.
    scan(790, 524, 9);
    chk("prefetch_addr", 32'(fb_addr), 32'd0);
    chk("prefetch_ce", 32'(fb_ce), 32'd1);
    scan(799, 524, 2);
    chk("origin_rgb", 32'(rgb), 32'hFF0000);
    chk("origin_mode", 32'(game_mode), 32'd0);

    // Replication and palette sweep along line 0.
    scan(1, 0, 1);
    chk("cx3_addr", 32'(fb_addr), 32'd0);
    scan(2, 0, 1);
    chk("cx4_addr", 32'(fb_addr), 32'd1);
    scan(3, 0, 2);
    chk("cx4_rgb", 32'(rgb), 32'hFF00FF);
    scan(5, 0, 4);
    chk("cx8_rgb", 32'(rgb), 32'hFFFF00);
    scan(9, 0, 31);

    // Line 4 starts at source row 1.
    scan(790, 3, 9);
    chk("cy4_addr", 32'(fb_addr), 32'd160);
    scan(799, 3, 12);

    // Last active source pixel and the edge of blanking.
    scan(630, 479, 5);
    chk("last_addr_636", 32'(fb_addr), 32'd19199);
    scan(635, 479, 3);
    chk("last_addr_639", 32'(fb_addr), 32'd19199);
    scan(638, 479, 1);
    chk("blank_addr_held", 32'(fb_addr), 32'd19199);
    chk("blank_ce_640", 32'(fb_ce), 32'd0);
    scan(639, 479, 12);
    chk("blank_rgb_650", 32'(rgb), 32'h0);

    // Vertical blanking and out-of-range coordinates.
    scan(790, 480, 30);
    scan(0, 500, 20);
    scan(1000, 600, 8);
    chk("oor_rgb", 32'(rgb), 32'h0);
    chk("oor_ce", 32'(fb_ce), 32'd0);

    // Mid-frame game request waits for the next frame.
    scan(0, 100, 10);
    game_start = 1'b1;
    game_rgb = 3'b011;
    scan(10, 100, 31);
    chk("midframe_mode", 32'(game_mode), 32'd0);
    chk("midframe_rgb", 32'(rgb), 32'hFFFF00);
    scan(780, 524, 21);
    chk("game_mode_origin", 32'(game_mode), 32'd1);
    chk("game_rgb_origin", 32'(rgb), 32'h00FFFF);
    scan(1, 0, 10);
    chk("game_rgb_cx10", 32'(rgb), 32'h00FFFF);
    chk("game_ce_gated", 32'(fb_ce), 32'd0);

    // Reset mid-frame for 3 cycles.
    scan(0, 200, 20);
    reset = 1'b1;
    scan(20, 200, 1);
    chk("midreset_rgb", 32'(rgb), 32'h0);
    chk("midreset_ce", 32'(fb_ce), 32'd0);
    chk("midreset_mode", 32'(game_mode), 32'd0);
    scan(21, 200, 2);
    reset = 1'b0;
    scan(23, 200, 20);
    chk("post_reset_rgb", 32'(rgb), 32'hFFFF00);
    chk("post_reset_mode", 32'(game_mode), 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
